// File: rtl/acc_hazard_tracker_pkg.sv
// rtl/acc_hazard_tracker_pkg.sv - opcode encodings, bypass select codes and decode class type
package acc_hazard_tracker_pkg;

    localparam int ACC_DATA_W = 8;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LDA   = 6'd1;
    localparam logic [5:0] OP_LDB   = 6'd2;
    localparam logic [5:0] OP_LDCA  = 6'd3;
    localparam logic [5:0] OP_LDCB  = 6'd4;
    localparam logic [5:0] OP_STA   = 6'd5;
    localparam logic [5:0] OP_STB   = 6'd6;
    localparam logic [5:0] OP_ADDA  = 6'd8;
    localparam logic [5:0] OP_ADDB  = 6'd9;
    localparam logic [5:0] OP_ADDCA = 6'd10;
    localparam logic [5:0] OP_ADDCB = 6'd11;
    localparam logic [5:0] OP_ANDA  = 6'd12;
    localparam logic [5:0] OP_ANDB  = 6'd13;
    localparam logic [5:0] OP_ANDCA = 6'd14;
    localparam logic [5:0] OP_ANDCB = 6'd15;
    localparam logic [5:0] OP_ORA   = 6'd16;
    localparam logic [5:0] OP_ORB   = 6'd17;
    localparam logic [5:0] OP_ORCA  = 6'd18;
    localparam logic [5:0] OP_ORCB  = 6'd19;
    localparam logic [5:0] OP_SUBA  = 6'd20;
    localparam logic [5:0] OP_SUBB  = 6'd21;
    localparam logic [5:0] OP_SUBCA = 6'd22;
    localparam logic [5:0] OP_SUBCB = 6'd23;
    localparam logic [5:0] OP_ASLA  = 6'd24;
    localparam logic [5:0] OP_ASLB  = 6'd25;
    localparam logic [5:0] OP_ASRA  = 6'd26;
    localparam logic [5:0] OP_ASRB  = 6'd27;
    localparam logic [5:0] OP_BRA   = 6'd32;
    localparam logic [5:0] OP_BEQ   = 6'd33;

    typedef enum logic [1:0] {
        FWD_SEL_RF    = 2'd0,
        FWD_SEL_EXMEM = 2'd1,
        FWD_SEL_MEMWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic rd_a;
        logic rd_b;
        logic wr_a;
        logic wr_b;
        logic is_load;
    } acc_class_t;

endpackage

// File: rtl/acc_hazard_tracker_if.sv
// rtl/acc_hazard_tracker_if.sv - decode/result/bypass bundle between the pipeline and the hazard tracker
interface acc_hazard_tracker_if
    import acc_hazard_tracker_pkg::*;
#(
    parameter int DATA_W = ACC_DATA_W
);
    logic              id_valid;
    logic [5:0]        id_opcode;
    logic              id_ready;
    logic              flush;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] mem_result;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic [DATA_W-1:0] fwd_a_data;
    logic [DATA_W-1:0] fwd_b_data;
    logic              stall;

    modport master (
        output id_valid, id_opcode, flush, ex_result, mem_result,
        input  id_ready, fwd_a_sel, fwd_b_sel, fwd_a_data, fwd_b_data, stall
    );

    modport slave (
        input  id_valid, id_opcode, flush, ex_result, mem_result,
        output id_ready, fwd_a_sel, fwd_b_sel, fwd_a_data, fwd_b_data, stall
    );
endinterface

// File: rtl/acc_hazard_tracker_decode.sv
// rtl/acc_hazard_tracker_decode.sv - acc_dest_decode: opcode to accumulator read/write/load class bits
module acc_dest_decode
    import acc_hazard_tracker_pkg::*;
(
    input  logic [5:0] i_opcode,
    output acc_class_t o_cls
);
    always_comb begin
        o_cls = '0;
        case (i_opcode)
            OP_LDA:  begin o_cls.wr_a = 1'b1; o_cls.is_load = 1'b1; end
            OP_LDB:  begin o_cls.wr_b = 1'b1; o_cls.is_load = 1'b1; end
            OP_LDCA: o_cls.wr_a = 1'b1;
            OP_LDCB: o_cls.wr_b = 1'b1;
            OP_STA:  o_cls.rd_a = 1'b1;
            OP_STB:  o_cls.rd_b = 1'b1;
            OP_ADDA, OP_ADDCA, OP_ANDA, OP_ANDCA, OP_ORA,
            OP_ORCA, OP_SUBA, OP_SUBCA, OP_ASLA, OP_ASRA:
                begin o_cls.rd_a = 1'b1; o_cls.wr_a = 1'b1; end
            OP_ADDB, OP_ADDCB, OP_ANDB, OP_ANDCB, OP_ORB,
            OP_ORCB, OP_SUBB, OP_SUBCB, OP_ASLB, OP_ASRB:
                begin o_cls.rd_b = 1'b1; o_cls.wr_b = 1'b1; end
            default: o_cls = '0;
        endcase
    end
endmodule

// File: rtl/acc_hazard_tracker.sv
// rtl/acc_hazard_tracker.sv - accumulator bypass source tracking and load-use stall; FWD_WB_PATH_EN enables MEM/WB bypass
module acc_hazard_tracker
    import acc_hazard_tracker_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    acc_hazard_tracker_if.slave  bus
);
    acc_class_t w_id_cls;

    acc_dest_decode u_id_decode (
        .i_opcode (bus.id_opcode),
        .o_cls    (w_id_cls)
    );

    logic                  r_ex_valid, r_ex_wr_a, r_ex_wr_b, r_ex_load;
    logic                  r_mem_valid, r_mem_wr_a, r_mem_wr_b, r_mem_load;
    logic [ACC_DATA_W-1:0] r_mem_data;
    logic                  w_haz_a, w_haz_b, w_stall, w_ex_load_en;
    logic                  w_mem_fwd_a, w_mem_fwd_b;

    assign w_mem_fwd_a = r_mem_valid & r_mem_wr_a & ~r_mem_load;
    assign w_mem_fwd_b = r_mem_valid & r_mem_wr_b & ~r_mem_load;

`ifdef FWD_WB_PATH_EN
    assign w_haz_a = r_ex_valid & r_ex_load & r_ex_wr_a;
    assign w_haz_b = r_ex_valid & r_ex_load & r_ex_wr_b;
`else
    // Anything that would sit in WB when the consumer reaches EX cannot be bypassed, so wait it out.
    assign w_haz_a = (r_ex_valid & r_ex_load & r_ex_wr_a)
                   | (r_mem_valid & r_mem_wr_a & ~(r_ex_valid & r_ex_wr_a));
    assign w_haz_b = (r_ex_valid & r_ex_load & r_ex_wr_b)
                   | (r_mem_valid & r_mem_wr_b & ~(r_ex_valid & r_ex_wr_b));
    logic w_unused_mem_result;
    assign w_unused_mem_result = ^bus.mem_result;
`endif

    assign w_stall = bus.id_valid & ~bus.flush
                   & ((w_id_cls.rd_a & w_haz_a) | (w_id_cls.rd_b & w_haz_b));
    assign w_ex_load_en = bus.id_valid & ~w_stall & ~bus.flush;

    assign bus.stall    = w_stall;
    assign bus.id_ready = ~w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_wr_a   <= 1'b0;
            r_ex_wr_b   <= 1'b0;
            r_ex_load   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_wr_a  <= 1'b0;
            r_mem_wr_b  <= 1'b0;
            r_mem_load  <= 1'b0;
            r_mem_data  <= '0;
        end else begin
            r_ex_valid  <= w_ex_load_en;
            r_ex_wr_a   <= w_ex_load_en & w_id_cls.wr_a;
            r_ex_wr_b   <= w_ex_load_en & w_id_cls.wr_b;
            r_ex_load   <= w_ex_load_en & w_id_cls.is_load;
            r_mem_valid <= r_ex_valid;
            r_mem_wr_a  <= r_ex_wr_a;
            r_mem_wr_b  <= r_ex_wr_b;
            r_mem_load  <= r_ex_load;
            r_mem_data  <= bus.ex_result;
        end
    end

`ifdef FWD_WB_PATH_EN
    logic                  r_wb_wr_a, r_wb_wr_b;
    logic [ACC_DATA_W-1:0] r_wb_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_wr_a <= 1'b0;
            r_wb_wr_b <= 1'b0;
            r_wb_data <= '0;
        end else begin
            r_wb_wr_a <= r_mem_valid & r_mem_wr_a;
            r_wb_wr_b <= r_mem_valid & r_mem_wr_b;
            if (r_mem_valid) begin
                r_wb_data <= bus.mem_result;
            end
        end
    end
`endif

    // MEM is checked first so the newest producer of an accumulator wins.
    always_comb begin
        bus.fwd_a_sel  = FWD_SEL_RF;
        bus.fwd_a_data = '0;
        bus.fwd_b_sel  = FWD_SEL_RF;
        bus.fwd_b_data = '0;
        if (w_mem_fwd_a) begin
            bus.fwd_a_sel  = FWD_SEL_EXMEM;
            bus.fwd_a_data = r_mem_data;
        end
`ifdef FWD_WB_PATH_EN
        else if (r_wb_wr_a) begin
            bus.fwd_a_sel  = FWD_SEL_MEMWB;
            bus.fwd_a_data = r_wb_data;
        end
`endif
        if (w_mem_fwd_b) begin
            bus.fwd_b_sel  = FWD_SEL_EXMEM;
            bus.fwd_b_data = r_mem_data;
        end
`ifdef FWD_WB_PATH_EN
        else if (r_wb_wr_b) begin
            bus.fwd_b_sel  = FWD_SEL_MEMWB;
            bus.fwd_b_data = r_wb_data;
        end
`endif
    end
endmodule
